// File: rtl/nway_cache_def.sv
// Shared cache definitions: default bus widths, cache typedefs and the port arbiter state enum.
package nway_cache_def;

   localparam int unsigned CACHE_ADDR_WIDTH = 16;
   localparam int unsigned CACHE_DATA_WIDTH = 32;
   localparam int unsigned CACHE_BE_WIDTH   = CACHE_DATA_WIDTH / 8;

   typedef logic [CACHE_ADDR_WIDTH-1:0] cache_addr_t;
   typedef logic [CACHE_DATA_WIDTH-1:0] cache_data_t;
   typedef logic [CACHE_BE_WIDTH-1:0]   cache_be_t;

   // One cache access as seen on the cache side of the arbiter.
   typedef struct packed {
      cache_addr_t addr;
      logic        we;
      cache_be_t   be;
      cache_data_t wdata;
   } cache_req_t;

   // Port arbiter state: idle, request outstanding at the cache, waiting for the response.
   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_REQ  = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_e;

   // Width of a requester index; never zero so a single-requester build still has a port.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sayuru_rr_select.sv
// Round-robin selector: first requester after i_last_owner (wrapping) whose request is set.
module sayuru_rr_select
   import nway_cache_def::*;
#(
   parameter int unsigned NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [idx_width(NUM_REQ)-1:0] i_last_owner,
   output logic                          o_valid_c,
   output logic [idx_width(NUM_REQ)-1:0] o_index_c
);

   localparam int unsigned IDX_W = idx_width(NUM_REQ);

   logic [IDX_W-1:0] w_cand;

   // Walk candidates last_owner+1 .. last_owner+NUM_REQ and keep the first one requesting.
   always_comb begin
      o_valid_c = 1'b0;
      o_index_c = '0;
      w_cand    = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         w_cand = IDX_W'((32'(i_last_owner) + i) % NUM_REQ);
         if (!o_valid_c && i_req[w_cand]) begin
            o_valid_c = 1'b1;
            o_index_c = w_cand;
         end
      end
   end

endmodule

// File: rtl/sayuru_port_arbiter.sv
// Round-robin arbiter sharing one cache port between NUM_REQ requesters, one transaction in flight.
module sayuru_port_arbiter
   import nway_cache_def::*;
#(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REQ    = 2
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NUM_REQ-1:0]                in_data_req_i,
   output logic [NUM_REQ-1:0]                in_data_gnt_o,
   output logic [NUM_REQ-1:0]                in_data_rvalid_o,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]     in_data_addr_i,
   input  logic [NUM_REQ-1:0]                in_data_we_i,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   in_data_be_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]     in_data_wdata_i,
   output logic [DATA_WIDTH-1:0]             in_data_rdata_o,
   output logic                              out_data_req_o,
   output logic [ADDR_WIDTH-1:0]             out_data_addr_o,
   output logic                              out_data_we_o,
   output logic [DATA_WIDTH/8-1:0]           out_data_be_o,
   output logic [DATA_WIDTH-1:0]             out_data_wdata_o,
   input  logic                              out_data_gnt_i,
   input  logic                              out_data_rvalid_i,
   input  logic [DATA_WIDTH-1:0]             out_data_rdata_i,
   output logic [idx_width(NUM_REQ)-1:0]     owner_o,
   output logic                              busy_o
);

   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned IDX_W    = idx_width(NUM_REQ);

   arb_state_e            r_state,      w_state_nxt;
   logic [IDX_W-1:0]      r_owner,      w_owner_nxt;
   logic [IDX_W-1:0]      r_last_owner, w_last_owner_nxt;
   logic                  r_req,        w_req_nxt;
   logic [ADDR_WIDTH-1:0] r_addr,       w_addr_nxt;
   logic                  r_we,         w_we_nxt;
   logic [BE_WIDTH-1:0]   r_be,         w_be_nxt;
   logic [DATA_WIDTH-1:0] r_wdata,      w_wdata_nxt;

   logic                  w_sel_valid;
   logic [IDX_W-1:0]      w_sel_idx;
   logic [NUM_REQ-1:0]    w_gnt;
   logic [NUM_REQ-1:0]    w_rvalid;
   logic [DATA_WIDTH-1:0] w_rdata;

   logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
   logic [BE_WIDTH-1:0]   w_be_arr    [NUM_REQ];
   logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

   // Unpack the per-requester request fields.
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_addr_arr[g]  = in_data_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_be_arr[g]    = in_data_be_i[g*BE_WIDTH +: BE_WIDTH];
      assign w_wdata_arr[g] = in_data_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
   end

   sayuru_rr_select #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_select (
      .i_req        (in_data_req_i),
      .i_last_owner (r_last_owner),
      .o_valid_c    (w_sel_valid),
      .o_index_c    (w_sel_idx)
   );

   // State and captured-request registers; last_owner resets to the top index so requester 0 wins first.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= ARB_IDLE;
         r_owner      <= '0;
         r_last_owner <= IDX_W'(NUM_REQ - 1);
         r_req        <= 1'b0;
         r_addr       <= '0;
         r_we         <= 1'b0;
         r_be         <= '0;
         r_wdata      <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_owner <= w_last_owner_nxt;
         r_req        <= w_req_nxt;
         r_addr       <= w_addr_nxt;
         r_we         <= w_we_nxt;
         r_be         <= w_be_nxt;
         r_wdata      <= w_wdata_nxt;
      end
   end

   // Next-state logic plus combinational routing of cache grant/response to the owner only.
   always_comb begin
      w_state_nxt      = r_state;
      w_owner_nxt      = r_owner;
      w_last_owner_nxt = r_last_owner;
      w_req_nxt        = r_req;
      w_addr_nxt       = r_addr;
      w_we_nxt         = r_we;
      w_be_nxt         = r_be;
      w_wdata_nxt      = r_wdata;
      w_gnt            = '0;
      w_rvalid         = '0;
      w_rdata          = '0;

      unique case (r_state)
         ARB_IDLE: begin
            // Cache gnt/rvalid here are stray and dropped.
            if (w_sel_valid) begin
               w_owner_nxt = w_sel_idx;
               w_req_nxt   = 1'b1;
               w_addr_nxt  = w_addr_arr[w_sel_idx];
               w_we_nxt    = in_data_we_i[w_sel_idx];
               w_be_nxt    = w_be_arr[w_sel_idx];
               w_wdata_nxt = w_wdata_arr[w_sel_idx];
               w_state_nxt = ARB_REQ;
            end
         end

         ARB_REQ: begin
            // rvalid without gnt cannot belong to this request and is ignored.
            w_gnt[r_owner] = out_data_gnt_i;
            if (out_data_gnt_i) begin
               w_req_nxt   = 1'b0;
               w_addr_nxt  = '0;
               w_we_nxt    = 1'b0;
               w_be_nxt    = '0;
               w_wdata_nxt = '0;
               if (out_data_rvalid_i) begin
                  w_rvalid[r_owner] = 1'b1;
                  w_rdata           = out_data_rdata_i;
                  w_last_owner_nxt  = r_owner;
                  w_state_nxt       = ARB_IDLE;
               end else begin
                  w_state_nxt = ARB_RESP;
               end
            end
         end

         ARB_RESP: begin
            w_rvalid[r_owner] = out_data_rvalid_i;
            if (out_data_rvalid_i) begin
               w_rdata          = out_data_rdata_i;
               w_last_owner_nxt = r_owner;
               w_state_nxt      = ARB_IDLE;
            end
         end

         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   assign in_data_gnt_o    = w_gnt;
   assign in_data_rvalid_o = w_rvalid;
   assign in_data_rdata_o  = w_rdata;
   assign out_data_req_o   = r_req;
   assign out_data_addr_o  = r_addr;
   assign out_data_we_o    = r_we;
   assign out_data_be_o    = r_be;
   assign out_data_wdata_o = r_wdata;
   assign owner_o          = r_owner;
   assign busy_o           = (r_state != ARB_IDLE);

endmodule

// File: tb/tb_sayuru_port_arbiter.sv
// Directed testbench for sayuru_port_arbiter: per-cycle vector table plus hand-written transactions.
module tb_sayuru_port_arbiter;

   logic        clk;
   logic        rst;
   logic [1:0]  req;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [31:0] addr;
   logic [1:0]  we;
   logic [7:0]  be;
   logic [63:0] wdata;
   logic [31:0] rdata;
   logic        oreq;
   logic [15:0] oaddr;
   logic        owe;
   logic [3:0]  obe;
   logic [31:0] owdata;
   logic        cgnt;
   logic        crv;
   logic [31:0] crdata;
   logic        owner;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   sayuru_port_arbiter dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .in_data_req_i     (req),
      .in_data_gnt_o     (gnt),
      .in_data_rvalid_o  (rvalid),
      .in_data_addr_i    (addr),
      .in_data_we_i      (we),
      .in_data_be_i      (be),
      .in_data_wdata_i   (wdata),
      .in_data_rdata_o   (rdata),
      .out_data_req_o    (oreq),
      .out_data_addr_o   (oaddr),
      .out_data_we_o     (owe),
      .out_data_be_o     (obe),
      .out_data_wdata_o  (owdata),
      .out_data_gnt_i    (cgnt),
      .out_data_rvalid_i (crv),
      .out_data_rdata_i  (crdata),
      .owner_o           (owner),
      .busy_o            (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One row per clock cycle: inputs driven at the falling edge, outputs checked 1ns later.
   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic [31:0] addr;
      logic [1:0]  we;
      logic [7:0]  be;
      logic [63:0] wdata;
      logic        cgnt;
      logic        crv;
      logic [31:0] crdata;
      logic [1:0]  e_gnt;
      logic [1:0]  e_rv;
      logic [31:0] e_rdata;
      logic        e_oreq;
      logic [15:0] e_oaddr;
      logic        e_owe;
      logic [3:0]  e_obe;
      logic [31:0] e_owdata;
      logic        e_owner;
      logic        e_busy;
   } vec_t;

   localparam int NV = 29;
   vec_t vecs [NV];

   function automatic vec_t mk(logic r, logic [1:0] rq, logic [31:0] ad, logic [1:0] w, logic [7:0] b,
                               logic [63:0] wd, logic cg, logic cr, logic [31:0] crd,
                               logic [1:0] eg, logic [1:0] ev, logic [31:0] erd, logic eq,
                               logic [15:0] ea, logic ew, logic [3:0] eb, logic [31:0] ewd,
                               logic eo, logic ebz);
      vec_t v;
      v.rst = r; v.req = rq; v.addr = ad; v.we = w; v.be = b; v.wdata = wd;
      v.cgnt = cg; v.crv = cr; v.crdata = crd;
      v.e_gnt = eg; v.e_rv = ev; v.e_rdata = erd; v.e_oreq = eq; v.e_oaddr = ea;
      v.e_owe = ew; v.e_obe = eb; v.e_owdata = ewd; v.e_owner = eo; v.e_busy = ebz;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Full requester/cache transaction with the given grant and response delays.
   task automatic txn(input logic exp_own, input int gd, input int rd, input logic [31:0] data);
      int t;
      logic [1:0] eg;
      eg = exp_own ? 2'b10 : 2'b01;
      t = 0;
      while (!oreq && t < 10) begin
         @(negedge clk); cgnt = 1'b0; crv = 1'b0; #1;
         t++;
      end
      chk("txn_req_seen", 64'(oreq), 64'(1'b1));
      chk("txn_owner", 64'(owner), 64'(exp_own));
      chk("txn_addr", 64'(oaddr), 64'(exp_own ? 16'h0300 : 16'h0200));
      for (int d = 0; d < gd; d++) begin
         @(negedge clk); cgnt = 1'b0; crv = 1'b0; #1;
         chk("txn_gnt_wait", 64'(gnt), 64'(2'b00));
         chk("txn_req_held", 64'(oreq), 64'(1'b1));
      end
      @(negedge clk); cgnt = 1'b1; crv = (rd == 0); crdata = data; #1;
      chk("txn_gnt", 64'(gnt), 64'(eg));
      if (rd == 0) chk("txn_rv_same", 64'(rvalid), 64'(eg));
      for (int d = 1; d < rd; d++) begin
         @(negedge clk); cgnt = 1'b0; crv = 1'b0; #1;
         chk("txn_rv_wait", 64'(rvalid), 64'(2'b00));
         chk("txn_busy_wait", 64'(busy), 64'(1'b1));
      end
      if (rd > 0) begin
         @(negedge clk); cgnt = 1'b0; crv = 1'b1; crdata = data; #1;
         chk("txn_rv", 64'(rvalid), 64'(eg));
         chk("txn_rdata", 64'(rdata), 64'(data));
      end
      @(negedge clk); cgnt = 1'b0; crv = 1'b0; #1;
      chk("txn_idle_gap", 64'(busy), 64'(1'b0));
      chk("txn_idle_rdata", 64'(rdata), 64'(0));
   endtask

   initial begin
      // rst req addr we be wdata cg cr crdata | gnt rv rdata oreq oaddr owe obe owdata owner busy
      vecs[0]  = mk(0, 2'b00, 32'h0, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0,        2'b00, 2'b00, 32'h0,        0, 16'h0,    0, 4'h0, 32'h0,        0, 0);
      vecs[1]  = mk(0, 2'b01, 32'h0000_0040, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0,       0, 16'h0,    0, 4'h0, 32'h0,        0, 0);
      vecs[2]  = mk(0, 2'b01, 32'h0000_0040, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0,       1, 16'h0040, 0, 4'h0, 32'h0,        0, 1);
      vecs[3]  = mk(0, 2'b01, 32'h0000_0040, 2'b00, 8'h00, 64'h0, 1, 0, 32'h0, 2'b01, 2'b00, 32'h0,       1, 16'h0040, 0, 4'h0, 32'h0,        0, 1);
      vecs[4]  = mk(0, 2'b00, 32'h0, 2'b00, 8'h00, 64'h0, 0, 1, 32'hDEADBEEF, 2'b00, 2'b01, 32'hDEADBEEF, 0, 16'h0,    0, 4'h0, 32'h0,        0, 1);
      vecs[5]  = mk(0, 2'b00, 32'h0, 2'b00, 8'h00, 64'h0, 0, 1, 32'h11111111, 2'b00, 2'b00, 32'h0,        0, 16'h0,    0, 4'h0, 32'h0,        0, 0);
      vecs[6]  = mk(1, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0,       0, 16'h0,    0, 4'h0, 32'h0,        0, 0);
      vecs[7]  = mk(0, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0,       0, 16'h0,    0, 4'h0, 32'h0,        0, 0);
      vecs[8]  = mk(0, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 1, 0, 32'h0, 2'b01, 2'b00, 32'h0,       1, 16'h0A00, 0, 4'h0, 32'h0,        0, 1);
      vecs[9]  = mk(0, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 0, 1, 32'hA0A0A0A0, 2'b00, 2'b01, 32'hA0A0A0A0, 0, 16'h0, 0, 4'h0, 32'h0,   0, 1);
      vecs[10] = mk(0, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0,       0, 16'h0,    0, 4'h0, 32'h0,        0, 0);
      vecs[11] = mk(0, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 1, 0, 32'h0, 2'b10, 2'b00, 32'h0,       1, 16'h0B10, 0, 4'h0, 32'h0,        1, 1);
      vecs[12] = mk(0, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 0, 1, 32'hB1B1B1B1, 2'b00, 2'b10, 32'hB1B1B1B1, 0, 16'h0, 0, 4'h0, 32'h0,   1, 1);
      vecs[13] = mk(0, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0,       0, 16'h0,    0, 4'h0, 32'h0,        1, 0);
      vecs[14] = mk(0, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 1, 1, 32'hC0C0C0C0, 2'b01, 2'b01, 32'hC0C0C0C0, 1, 16'h0A00, 0, 4'h0, 32'h0, 0, 1);
      vecs[15] = mk(0, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0,       0, 16'h0,    0, 4'h0, 32'h0,        0, 0);
      vecs[16] = mk(0, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 1, 0, 32'h0, 2'b10, 2'b00, 32'h0,       1, 16'h0B10, 0, 4'h0, 32'h0,        1, 1);
      vecs[17] = mk(0, 2'b11, 32'h0B10_0A00, 2'b00, 8'h00, 64'h0, 0, 1, 32'hD1D1D1D1, 2'b00, 2'b10, 32'hD1D1D1D1, 0, 16'h0, 0, 4'h0, 32'h0,   1, 1);
      vecs[18] = mk(0, 2'b00, 32'h0, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0,        2'b00, 2'b00, 32'h0,        0, 16'h0,    0, 4'h0, 32'h0,        1, 0);
      vecs[19] = mk(0, 2'b10, 32'h0100_0000, 2'b10, 8'hF0, 64'h12345678_00000000, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0, 0, 16'h0, 0, 4'h0, 32'h0, 1, 0);
      vecs[20] = mk(0, 2'b10, 32'h0100_0000, 2'b10, 8'hF0, 64'h12345678_00000000, 0, 1, 32'h99, 2'b00, 2'b00, 32'h0, 1, 16'h0100, 1, 4'hF, 32'h12345678, 1, 1);
      vecs[21] = mk(0, 2'b00, 32'h0, 2'b00, 8'h00, 64'h0, 1, 0, 32'h0,        2'b10, 2'b00, 32'h0,        1, 16'h0100, 1, 4'hF, 32'h12345678, 1, 1);
      vecs[22] = mk(0, 2'b00, 32'h0, 2'b00, 8'h00, 64'h0, 0, 1, 32'h5A5A5A5A, 2'b00, 2'b10, 32'h5A5A5A5A, 0, 16'h0,    0, 4'h0, 32'h0,        1, 1);
      vecs[23] = mk(0, 2'b00, 32'h0, 2'b00, 8'h00, 64'h0, 1, 0, 32'h0,        2'b00, 2'b00, 32'h0,        0, 16'h0,    0, 4'h0, 32'h0,        1, 0);
      vecs[24] = mk(0, 2'b01, 32'h0300_0200, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0,       0, 16'h0,    0, 4'h0, 32'h0,        1, 0);
      vecs[25] = mk(0, 2'b01, 32'h0300_0200, 2'b00, 8'h00, 64'h0, 1, 0, 32'h0, 2'b01, 2'b00, 32'h0,       1, 16'h0200, 0, 4'h0, 32'h0,        0, 1);
      vecs[26] = mk(1, 2'b00, 32'h0300_0200, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0,       0, 16'h0,    0, 4'h0, 32'h0,        0, 0);
      vecs[27] = mk(0, 2'b11, 32'h0300_0200, 2'b00, 8'h00, 64'h0, 0, 1, 32'h77, 2'b00, 2'b00, 32'h0,      0, 16'h0,    0, 4'h0, 32'h0,        0, 0);
      vecs[28] = mk(0, 2'b11, 32'h0300_0200, 2'b00, 8'h00, 64'h0, 0, 0, 32'h0, 2'b00, 2'b00, 32'h0,       1, 16'h0200, 0, 4'h0, 32'h0,        0, 1);

      rst = 1'b1; req = '0; addr = '0; we = '0; be = '0; wdata = '0;
      cgnt = 1'b0; crv = 1'b0; crdata = '0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst = vecs[i].rst; req = vecs[i].req; addr = vecs[i].addr; we = vecs[i].we;
         be = vecs[i].be; wdata = vecs[i].wdata; cgnt = vecs[i].cgnt; crv = vecs[i].crv;
         crdata = vecs[i].crdata;
         #1;
         chk($sformatf("row%0d_gnt", i),    64'(gnt),    64'(vecs[i].e_gnt));
         chk($sformatf("row%0d_rvalid", i), 64'(rvalid), 64'(vecs[i].e_rv));
         chk($sformatf("row%0d_rdata", i),  64'(rdata),  64'(vecs[i].e_rdata));
         chk($sformatf("row%0d_oreq", i),   64'(oreq),   64'(vecs[i].e_oreq));
         chk($sformatf("row%0d_oaddr", i),  64'(oaddr),  64'(vecs[i].e_oaddr));
         chk($sformatf("row%0d_owe", i),    64'(owe),    64'(vecs[i].e_owe));
         chk($sformatf("row%0d_obe", i),    64'(obe),    64'(vecs[i].e_obe));
         chk($sformatf("row%0d_owdata", i), 64'(owdata), 64'(vecs[i].e_owdata));
         chk($sformatf("row%0d_owner", i),  64'(owner),  64'(vecs[i].e_owner));
         chk($sformatf("row%0d_busy", i),   64'(busy),   64'(vecs[i].e_busy));
      end

      // Continuous requests from both ports with varied cache timing: owners must alternate.
      txn(1'b0, 0, 3, 32'h0000_1000);
      txn(1'b1, 1, 2, 32'h0000_1111);
      txn(1'b0, 2, 1, 32'h0000_2000);
      txn(1'b1, 3, 0, 32'h0000_2111);

      req = '0;
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
